// File: rtl/counter_snapshot_fifo.sv
// Snapshot FIFO for a dual 64-bit counter: each Trig captures {Cnt1, Cnt0} coherently,
// and each entry drains as four 32-bit words over a valid/ready port.
module counter_snapshot_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [63:0]   Cnt0,
   input  logic [63:0]   Cnt1,
   input  logic          Trig,
   input  logic          Clr,
   input  logic          RdReady,
   output logic [31:0]   RdData,
   output logic          RdValid,
   output logic          RdLast,
   output logic [AW:0]   Count,
   output logic          Full,
   output logic          Empty,
   output logic          Overflow
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [127:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [1:0]    wi;
   logic          overflow;
   logic          xfer;
   logic          pop;
   logic          push;
   logic [127:0]  head;

   assign Count    = count;
   assign Empty    = (count == '0);
   assign Full     = (count == FULL_COUNT);
   assign RdValid  = !Empty;
   assign RdLast   = RdValid && (wi == 2'd3);
   assign Overflow = overflow;

   assign xfer = RdValid && RdReady;
   assign pop  = xfer && (wi == 2'd3);
   // A full FIFO still accepts a push when the head entry leaves on the same edge.
   assign push = Trig && (!Full || pop);

   assign head = mem[rd_ptr];

   always_comb begin
      RdData = '0;
      if (!Empty) begin
         case (wi)
            2'd0:    RdData = head[31:0];
            2'd1:    RdData = head[63:32];
            2'd2:    RdData = head[95:64];
            default: RdData = head[127:96];
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= {Cnt1, Cnt0};
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         wi       <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         // Two-bit word index wraps 3 -> 0 exactly when the entry pops.
         if (xfer) wi <= wi + 2'd1;
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
         if (Trig && !push) overflow <= 1'b1;
         else if (Clr)      overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_counter_snapshot_fifo.sv
// Scoreboard bench for counter_snapshot_fifo: expected words are queued when snapshots
// are triggered and compared as the DUT presents them on the read port.
module tb_counter_snapshot_fifo;

   localparam int DEPTH = 4;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [63:0] Cnt0 = '0;
   logic [63:0] Cnt1 = '0;
   logic        Trig = 1'b0;
   logic        Clr = 1'b0;
   logic        RdReady = 1'b0;
   logic [31:0] RdData;
   logic        RdValid;
   logic        RdLast;
   logic [2:0]  Count;
   logic        Full;
   logic        Empty;
   logic        Overflow;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   int exp_count = 0;
   int exp_wi = 0;
   logic exp_ovf = 1'b0;

   counter_snapshot_fifo #(.DEPTH(4), .AW(2)) dut (
      .Clk(Clk), .Reset(Reset), .Cnt0(Cnt0), .Cnt1(Cnt1), .Trig(Trig), .Clr(Clr),
      .RdReady(RdReady), .RdData(RdData), .RdValid(RdValid), .RdLast(RdLast),
      .Count(Count), .Full(Full), .Empty(Empty), .Overflow(Overflow)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic push_snap(input logic [63:0] c0, input logic [63:0] c1);
      Cnt0 = c0; Cnt1 = c1; Trig = 1'b1;
      tick();
      Trig = 1'b0;
      Cnt0 = ~c0; Cnt1 = ~c1;
      if (exp_count < DEPTH) begin
         exp_q.push_back(c0[31:0]); exp_q.push_back(c0[63:32]);
         exp_q.push_back(c1[31:0]); exp_q.push_back(c1[63:32]);
         exp_count++;
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   task automatic drain(input int n);
      logic [31:0] w;
      for (int k = 0; k < n; k++) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL drain_model_empty k=%0d", k);
         end else begin
            w = exp_q.pop_front();
            if (RdValid !== 1'b1 || RdData !== w || RdLast !== (exp_wi == 3)) begin
               errors++;
               $display("FAIL drain_word k=%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                        k, RdValid, RdData, RdLast, w, (exp_wi == 3));
            end
         end
         RdReady = 1'b1;
         tick();
         if (exp_wi == 3) begin exp_wi = 0; exp_count--; end
         else exp_wi++;
      end
      RdReady = 1'b0;
   endtask

   task automatic test_reset();
      #1 Reset = 1'b0;
      repeat (3) tick();
      Reset = 1'b1;
      tick();
      checks++;
      if (Count !== 3'd0 || Empty !== 1'b1 || RdValid !== 1'b0 || Overflow !== 1'b0 ||
          RdData !== 32'h0 || Full !== 1'b0 || RdLast !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got cnt=%0d e=%0b v=%0b o=%0b d=%h f=%0b l=%0b want 0 1 0 0 0 0 0",
                  Count, Empty, RdValid, Overflow, RdData, Full, RdLast);
      end
   endtask

   task automatic test_single();
      push_snap(64'h0000_0002_0000_0001, 64'h0000_0004_0000_0003);
      checks++;
      if (RdValid !== 1'b1 || Count !== 3'd1) begin
         errors++; $display("FAIL single_latency got v=%0b cnt=%0d want v=1 cnt=1", RdValid, Count);
      end
      drain(4);
      checks++;
      if (Empty !== 1'b1 || RdValid !== 1'b0 || RdData !== 32'h0) begin
         errors++; $display("FAIL single_empty got e=%0b v=%0b d=%h want 1 0 0", Empty, RdValid, RdData);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         push_snap(64'(i), 64'(i + 100));
         if (i == 4) begin
            checks++;
            if (Full !== 1'b1 || Overflow !== 1'b0) begin
               errors++; $display("FAIL ovf_full4 got f=%0b o=%0b want f=1 o=0", Full, Overflow);
            end
         end
      end
      checks++;
      if (Overflow !== exp_ovf || Count !== 3'(exp_count) || Full !== 1'b1) begin
         errors++; $display("FAIL ovf_dropped got o=%0b cnt=%0d f=%0b want o=%0b cnt=%0d f=1",
                            Overflow, Count, Full, exp_ovf, exp_count);
      end
      drain(16);
      checks++;
      if (Empty !== 1'b1 || Overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky got e=%0b o=%0b want e=1 o=1", Empty, Overflow);
      end
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      exp_ovf = 1'b0;
      checks++;
      if (Overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clear got o=%0b want o=0", Overflow);
      end
   endtask

   task automatic test_full_pop_push();
      for (int i = 0; i < 4; i++) push_snap(64'hA000_0000_0000_0000 + 64'(i), 64'hB000_0000_0000_0000 + 64'(i));
      drain(3);
      checks++;
      if (RdLast !== 1'b1 || Full !== 1'b1) begin
         errors++; $display("FAIL fpp_setup got l=%0b f=%0b want l=1 f=1", RdLast, Full);
      end
      Cnt0 = 64'hC0DE_0001_C0DE_0000; Cnt1 = 64'hC0DE_0003_C0DE_0002;
      RdReady = 1'b1; Trig = 1'b1;
      checks++;
      if (RdData !== exp_q[0]) begin
         errors++; $display("FAIL fpp_word3 got d=%h want d=%h", RdData, exp_q[0]);
      end
      tick();
      RdReady = 1'b0; Trig = 1'b0;
      void'(exp_q.pop_front());
      exp_wi = 0;
      exp_q.push_back(32'hC0DE_0000); exp_q.push_back(32'hC0DE_0001);
      exp_q.push_back(32'hC0DE_0002); exp_q.push_back(32'hC0DE_0003);
      checks++;
      if (Count !== 3'd4 || Overflow !== 1'b0 || Full !== 1'b1) begin
         errors++; $display("FAIL fpp_accept got cnt=%0d o=%0b f=%0b want cnt=4 o=0 f=1", Count, Overflow, Full);
      end
      drain(16);
   endtask

   task automatic test_stall();
      logic pattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      push_snap(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (RdValid !== 1'b1 || RdData !== exp_q[0] || RdLast !== (exp_wi == 3)) begin
            errors++;
            $display("FAIL stall_cycle k=%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                     k, RdValid, RdData, RdLast, exp_q[0], (exp_wi == 3));
         end
         RdReady = pattern[k];
         tick();
         if (pattern[k]) begin
            void'(exp_q.pop_front());
            if (exp_wi == 3) begin exp_wi = 0; exp_count--; end
            else exp_wi++;
         end
      end
      RdReady = 1'b0;
      checks++;
      if (Empty !== 1'b1 || exp_q.size() != 0) begin
         errors++; $display("FAIL stall_end got e=%0b left=%0d want e=1 left=0", Empty, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_drain();
      push_snap(64'hDEAD_0001_DEAD_0000, 64'hDEAD_0003_DEAD_0002);
      push_snap(64'hBEEF_0001_BEEF_0000, 64'hBEEF_0003_BEEF_0002);
      drain(2);
      Reset = 1'b0;
      #1;
      checks++;
      if (Empty !== 1'b1 || Count !== 3'd0 || RdValid !== 1'b0 || RdData !== 32'h0 || RdLast !== 1'b0) begin
         errors++; $display("FAIL rst_mid got e=%0b cnt=%0d v=%0b d=%h l=%0b want 1 0 0 0 0",
                            Empty, Count, RdValid, RdData, RdLast);
      end
      tick();
      Reset = 1'b1;
      exp_q.delete(); exp_count = 0; exp_wi = 0; exp_ovf = 1'b0;
      tick();
      push_snap(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
      drain(4);
      checks++;
      if (Empty !== 1'b1) begin
         errors++; $display("FAIL rst_after got e=%0b want e=1", Empty);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_pop_push();
      test_stall();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_snapshot_fifo.md
Name: counter_snapshot_fifo

Overview:
- Downstream consumer of the dual 64-bit counter block; takes its Output0 and Output1 values on the Cnt0 and Cnt1 inputs.
- On each Trig pulse, captures a coherent snapshot of both counters into a small FIFO.
- Drains each snapshot as four 32-bit words over a valid/ready read port for a 32-bit host or bus.
- Flags snapshots lost to a full FIFO with a sticky overflow bit.

Parameters:
DEPTH  4  number of snapshot entries; power of two, 2..16
AW  2  log2(DEPTH); pointer width

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
Cnt0  input  64  counter value 0 (from counter Output0)
Cnt1  input  64  counter value 1 (from counter Output1)
Trig  input  1  capture request, sampled at posedge
Clr  input  1  synchronous clear of Overflow
RdReady  input  1  consumer accepts RdData this cycle
RdData  output  32  current word of head snapshot
RdValid  output  1  RdData valid (FIFO not empty)
RdLast  output  1  current word is the last (word 3) of the head snapshot
Count  output  AW+1  number of stored snapshots, 0..DEPTH
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
Overflow  output  1  sticky flag: at least one Trig was dropped

Behaviour:
- Interface: one clock (Clk). Reset is asynchronous and active-low, and the port is named Reset.
- Reset asserted (Reset=0), immediately and without waiting for a clock edge:
  - write pointer, read pointer, Count and word index all go to 0;
  - Overflow=0, Empty=1, Full=0, RdValid=0, RdLast=0, RdData=0.
  - Storage contents need not be cleared.
- Entry format: {Cnt1, Cnt0}, 128 bits, captured from both inputs at the same posedge so the pair is coherent.
- Push: at a posedge with Trig=1, accept if Count<DEPTH, or if Count==DEPTH and a pop completes in the same cycle.
  - Accepted: write at the write pointer, then wr_ptr+1 modulo DEPTH.
  - Not accepted: Trig is dropped and Overflow<=1.
- Read serializer: word index wi (0..3) is the read-side state.
  - RdData is combinational from the head entry and wi: wi=0 -> Cnt0[31:0]; 1 -> Cnt0[63:32]; 2 -> Cnt1[31:0]; 3 -> Cnt1[63:32].
  - RdData=0 when Empty.
  - RdValid = !Empty; RdLast = RdValid && wi==3.
- Transfer: RdValid && RdReady at a posedge.
  - If wi<3: wi+1.
  - If wi==3: wi<=0, the entry is popped, rd_ptr+1 modulo DEPTH.
  - RdData must hold stable while RdValid=1 and RdReady=0.
- Count update: +1 on an accepted push without a pop; -1 on a pop without a push; unchanged when both or neither happen.
- Pointers wrap modulo DEPTH. Full and Empty derive from Count only.
- Push on an empty FIFO: RdValid rises the cycle after the push edge, i.e. 1-cycle write-to-read latency. No same-cycle bypass.
- Overflow and Clr:
  - Overflow clears only on Reset or on Clr=1 at a posedge.
  - If Clr and a dropped Trig occur in the same cycle, Overflow<=1 (set wins).
- Cnt0 and Cnt1 are sampled only on an accepted push. Changes at any other time have no effect.
- Reset asserted mid-drain: the partial snapshot is discarded, wi returns to 0 and the FIFO becomes empty.
- RdReady while Empty: ignored; no state change.

Test Plan:
- Reset=0 for 3 cycles, then 1 -> Count=0, Empty=1, RdValid=0, Overflow=0, RdData=0.
- Cnt0=64'h0000_0002_0000_0001, Cnt1=64'h0000_0004_0000_0003, one Trig pulse, then RdReady=1 -> RdValid rises 1 cycle after the Trig edge; words 1,2,3,4 on consecutive cycles; RdLast=1 only on word 4; then Empty=1.
- Five Trig pulses with Cnt0=1..5 and RdReady=0 (DEPTH=4) -> Full=1 after the 4th, 5th dropped, Overflow=1, Count=4. Then drain 16 words -> Cnt0 low words read 1,2,3,4. Then Clr=1 -> Overflow=0.
- FIFO full with wi=3 and RdReady=1, Trig=1 in the same cycle -> push accepted, Count stays 4, Overflow stays 0.
- Toggle RdReady 1,0,0,1 during a drain -> RdData and RdLast hold during the stalls; the word order is unchanged.
- Reset=0 pulse while wi=2 with 2 entries stored -> immediate Empty=1, Count=0. After release, a new Trig snapshot reads from word 0.
